path_reconstructor: RTL
=======================

PATH_RECONSTRUCTOR -- requirements
Module: path_reconstructor

Interface
REQ-001 SHALL have parameter MAX_NODES, default 1024, maximum number of graph nodes and stack depth.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10, node index width (log2 MAX_NODES).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to reconstruct a path; sampled only in IDLE.
REQ-006 SHALL have port source, input, 16, path start node index; sampled with start.
REQ-007 SHALL have port destination, input, 16, path end node index; sampled with start.
REQ-008 SHALL have port prev_read_address, output, INDEX_WIDTH, previous-vector read address to the Dijkstra core.
REQ-009 SHALL have port prev_read_data, input, INDEX_WIDTH, previous-vector entry, valid exactly one cycle after the address.
REQ-010 SHALL have port out_valid, output, 1, out_node is valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_node when high with out_valid.
REQ-012 SHALL have port out_node, output, 16, path node, zero-extended from INDEX_WIDTH.
REQ-013 SHALL have port out_last, output, 1, high with the final node (destination).
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on completion or error.
REQ-016 SHALL have port error, output, 1, valid with done; 1 = no path was emitted.
REQ-017 SHALL have port path_length, output, 16, node count of the last completed path, 0 after error.

Function
REQ-018 SHALL implement states IDLE, PUSH, WAIT, EMIT; an internal LIFO of MAX_NODES x INDEX_WIDTH; a count register 0..MAX_NODES; and a cur register.
REQ-019 IDLE with start=1: if source or destination >= MAX_NODES, SHALL pulse done with error=1 next cycle and stay in IDLE; otherwise cur<=destination, count<=0, go to PUSH.
REQ-020 PUSH: SHALL write cur to LIFO[count], increment count, and drive prev_read_address=cur in the same cycle.
REQ-021 PUSH: if cur==source, SHALL go to EMIT; else go to WAIT; one hop therefore costs exactly 2 cycles.
REQ-022 WAIT: if prev_read_data is all ones (unreachable sentinel), SHALL abort with done=1, error=1 and go to IDLE.
REQ-023 WAIT: if count==MAX_NODES (cycle or corrupt vector), SHALL abort with done=1, error=1 and go to IDLE.
REQ-024 WAIT otherwise: SHALL load cur<=prev_read_data and go to PUSH.
REQ-025 EMIT: SHALL present out_node=LIFO[count-1] with out_valid=1, so nodes appear source-first and destination-last.
REQ-026 EMIT: out_last SHALL equal (count==1).
REQ-027 EMIT: on out_valid&&out_ready, count SHALL decrement; out_node, out_valid and out_last SHALL be held stable while out_ready=0.
REQ-028 On the handshake with out_last=1, SHALL go to IDLE, pulse done=1 with error=0 on the following cycle, and hold path_length at the path's node count.
REQ-029 start outside IDLE SHALL be ignored; no queuing.
REQ-030 source==destination SHALL yield a 1-node path with no wait cycles: start, PUSH, EMIT.
REQ-031 out_valid SHALL be 0 outside EMIT; prev_read_address SHALL be don't-care outside PUSH.

Reset
REQ-032 While reset=0: state=IDLE, count=0, cur=0, busy=0, done=0, error=0, out_valid=0, out_last=0, out_node=0, path_length=0; LIFO contents need not be cleared.
REQ-033 Reset asserted mid-walk or mid-emit SHALL abort immediately, emit no further nodes, and produce no done pulse.
REQ-034 After reset deassertion, the block SHALL accept start on the first rising edge.

Verification
REQ-035 Scenario: prev = {3->2, 2->0}, source=0, destination=3, out_ready=1 -> out_node 0,2,3; out_last on node 3; done, error=0, path_length=3; first out_valid 5 cycles after start.
REQ-036 Scenario: source=destination=7 -> single node 7 with out_last=1; path_length=1; no read cycles.
REQ-037 Scenario: prev[5]=all ones, source=0, destination=5 -> no out_valid; done with error=1; path_length=0.
REQ-038 Scenario: prev forms cycle 4->6->4, source=0, destination=4 -> error after count reaches MAX_NODES; no output emitted.
REQ-039 Scenario: 3-node path with out_ready toggling 1,0,0,1,... -> out_node held stable while stalled; order 0,2,3 preserved; second start during EMIT ignored.
REQ-040 Scenario: reset pulsed low during EMIT after first node -> out_valid=0 and busy=0 immediately; no done; a new start then completes normally.

Source files
------------

// File: rtl/path_reconstructor.sv
// Walks a Dijkstra previous-vector from destination back to source into a LIFO,
// then streams the path out source-first over a valid/ready handshake.
module path_reconstructor #(
  parameter int MAX_NODES   = 1024,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            source,
  input  logic [15:0]            destination,
  output logic [INDEX_WIDTH-1:0] prev_read_address,
  input  logic [INDEX_WIDTH-1:0] prev_read_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_node,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [15:0]            path_length
);

  localparam int CW = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] FULL  = CW'(MAX_NODES);
  localparam logic [31:0]   LIMIT = 32'(MAX_NODES);

  typedef enum logic [1:0] {IDLE, PUSH, WAIT, EMIT} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          count, count_nx;
  logic [CW-1:0]          length, length_nx;
  logic [INDEX_WIDTH-1:0] cur, cur_nx;
  logic [INDEX_WIDTH-1:0] src, src_nx;
  logic                   done_nx, error_nx;
  logic [15:0]            path_length_nx;
  logic                   lifo_we;
  logic                   out_of_range;
  logic [INDEX_WIDTH-1:0] top_idx;

  logic [INDEX_WIDTH-1:0] lifo [MAX_NODES];

  assign out_of_range = (32'(source) >= LIMIT) || (32'(destination) >= LIMIT);
  assign top_idx      = INDEX_WIDTH'(count - CW'(1));
  assign busy         = (state != IDLE);

  always_comb begin
    state_nx          = state;
    count_nx          = count;
    length_nx         = length;
    cur_nx            = cur;
    src_nx            = src;
    done_nx           = 1'b0;
    error_nx          = 1'b0;
    path_length_nx    = path_length;
    lifo_we           = 1'b0;
    prev_read_address = cur;
    out_valid         = 1'b0;
    out_last          = 1'b0;
    out_node          = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (out_of_range) begin
            done_nx        = 1'b1;
            error_nx       = 1'b1;
            path_length_nx = '0;
          end else begin
            cur_nx   = destination[INDEX_WIDTH-1:0];
            src_nx   = source[INDEX_WIDTH-1:0];
            count_nx = '0;
            state_nx = PUSH;
          end
        end
      end
      PUSH: begin
        lifo_we  = 1'b1;
        count_nx = count + CW'(1);
        if (cur == src) begin
          length_nx = count + CW'(1);
          state_nx  = EMIT;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // all-ones entry marks an unreachable node; a full stack means a loop
        if ((&prev_read_data) || (count == FULL)) begin
          done_nx        = 1'b1;
          error_nx       = 1'b1;
          path_length_nx = '0;
          state_nx       = IDLE;
        end else begin
          cur_nx   = prev_read_data;
          state_nx = PUSH;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_node  = 16'(lifo[top_idx]);
        out_last  = (count == CW'(1));
        if (out_ready) begin
          count_nx = count - CW'(1);
          if (out_last) begin
            done_nx        = 1'b1;
            path_length_nx = 16'(length);
            state_nx       = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      length      <= '0;
      cur         <= '0;
      src         <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      path_length <= '0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      length      <= length_nx;
      cur         <= cur_nx;
      src         <= src_nx;
      done        <= done_nx;
      error       <= error_nx;
      path_length <= path_length_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (lifo_we) lifo[INDEX_WIDTH'(count)] <= cur;
  end

endmodule
